// File: rtl/aes_batch_io.sv
// Stream adapter in front of an N-lane parallel AES array: gathers up to N
// (text, key) pairs, launches the array, then replays the N results one lane at a time.
module aes_batch_io #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_text,
    input  logic [127:0]       in_key,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_text,
    output logic               out_last,
    output logic               aes_start,
    output logic [128*N-1:0]   aes_plain_text,
    output logic [128*N-1:0]   aes_cipher_key,
    input  logic               aes_done,
    input  logic [128*N-1:0]   aes_cipher_text,
    output logic               busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  count, count_n;
    logic [CW-1:0]  rd_ptr, sel_ptr;
    logic [127:0]   slot_text [N];
    logic [127:0]   slot_key  [N];
    logic [127:0]   result    [N];
    logic [127:0]   sel_text;
    logic           done_q;
    logic           in_fire, do_flush, capture, out_fire, last_fire;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FILL;
        else     state <= state_n;
    end

    // A flush that coincides with a handshake is not taken here; it is seen again next cycle.
    always_comb begin
        state_n   = state;
        in_fire   = 1'b0;
        do_flush  = 1'b0;
        capture   = 1'b0;
        out_fire  = 1'b0;
        last_fire = 1'b0;
        case (state)
            S_FILL: begin
                in_fire = in_valid;
                if (in_valid) begin
                    if (count == CW'(N - 1)) state_n = S_LAUNCH;
                end else if (flush && count != '0) begin
                    do_flush = 1'b1;
                    state_n  = S_LAUNCH;
                end
            end
            S_LAUNCH: state_n = S_WAIT;
            S_WAIT: begin
                if (aes_done && !done_q) begin
                    capture = 1'b1;
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_fire  = out_valid && out_ready;
                last_fire = out_fire && out_last;
                if (last_fire) state_n = S_FILL;
            end
            default: state_n = S_FILL;
        endcase
    end

    always_comb begin
        count_n = count;
        if (in_fire)        count_n = count + CW'(1);
        else if (last_fire) count_n = '0;
        sel_ptr  = out_fire ? rd_ptr + CW'(1) : rd_ptr;
        sel_text = '0;
        for (int j = 0; j < N; j++) begin
            if (sel_ptr == CW'(j)) sel_text = result[j];
        end
    end

    // The first DRAIN cycle only presents lane 0, so out_valid trails the capture by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            rd_ptr    <= '0;
            done_q    <= 1'b0;
            in_ready  <= 1'b1;
            aes_start <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_text  <= '0;
            out_last  <= 1'b0;
            for (int j = 0; j < N; j++) begin
                slot_text[j] <= '0;
                slot_key[j]  <= '0;
                result[j]    <= '0;
            end
        end else begin
            count     <= count_n;
            done_q    <= aes_done;
            in_ready  <= (state_n == S_FILL);
            aes_start <= (state_n == S_LAUNCH);
            busy      <= !(state_n == S_FILL && count_n == '0);
            for (int j = 0; j < N; j++) begin
                if (in_fire && count == CW'(j)) begin
                    slot_text[j] <= in_text;
                    slot_key[j]  <= in_key;
                end else if (do_flush && CW'(j) >= count) begin
                    slot_text[j] <= '0;
                    slot_key[j]  <= '0;
                end
                if (capture) result[j] <= aes_cipher_text[j*128 +: 128];
            end
            if (capture) rd_ptr <= '0;
            if (state == S_DRAIN) begin
                if (last_fire) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    rd_ptr    <= '0;
                end else begin
                    out_valid <= 1'b1;
                    out_text  <= sel_text;
                    out_last  <= (sel_ptr == count - CW'(1));
                    rd_ptr    <= sel_ptr;
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign aes_plain_text[g*128 +: 128] = slot_text[g];
        assign aes_cipher_key[g*128 +: 128] = slot_key[g];
    end

endmodule

// File: tb/tb_aes_batch_io.sv
// Directed bench for aes_batch_io: full, partial and stalled batches, stale done,
// flush corner cases and reset during WAIT, against a hand-driven array model.
module tb_aes_batch_io;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [127:0]     in_text, in_key;
    logic             flush;
    logic             out_valid, out_ready, out_last;
    logic [127:0]     out_text;
    logic             aes_start, aes_done, busy;
    logic [128*N-1:0] aes_plain_text, aes_cipher_key, aes_cipher_text;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [127:0]     vt [N];
    logic [127:0]     vk [N];
    logic [127:0]     exp_ct [N];

    aes_batch_io #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text), .out_last(out_last),
        .aes_start(aes_start), .aes_plain_text(aes_plain_text), .aes_cipher_key(aes_cipher_key),
        .aes_done(aes_done), .aes_cipher_text(aes_cipher_text),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_vectors(input int base);
        for (int j = 0; j < N; j++) begin
            vt[j] = {120'h0, 8'(base + j + 1)};
            vk[j] = {32'h4B455900, 88'h0, 8'(base + j + 1)};
        end
    endtask

    task automatic set_cipher(input int batch);
        for (int j = 0; j < N; j++) begin
            exp_ct[j] = {32'hC1C1C1C1, 32'(batch), 32'(j), 32'hDEAD0000};
            aes_cipher_text[j*128 +: 128] = exp_ct[j];
        end
    endtask

    task automatic push(input logic [127:0] t, input logic [127:0] k);
        in_valid = 1'b1;
        in_text  = t;
        in_key   = k;
        chk("in_ready_fill", 128'(in_ready), 128'd1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic check_lanes(input int filled);
        for (int j = 0; j < N; j++) begin
            chk("plain_lane", aes_plain_text[j*128 +: 128], (j < filled) ? vt[j] : 128'h0);
            chk("key_lane", aes_cipher_key[j*128 +: 128], (j < filled) ? vk[j] : 128'h0);
        end
    endtask

    // Every cycle that out_valid is high is compared, so stalled cycles prove stability.
    task automatic drain(input int n, input bit bp);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        while (idx < n && cyc < 200) begin
            rdy = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            out_ready = rdy;
            if (out_valid) begin
                chk("out_text", out_text, exp_ct[idx]);
                chk("out_last", 128'(out_last), 128'(idx == n - 1));
                if (rdy) idx++;
            end
            tick;
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_count", 128'(idx), 128'(n));
        chk("no_extra_out", 128'(out_valid), 128'd0);
        chk("in_ready_after", 128'(in_ready), 128'd1);
    endtask

    initial begin
        int starts;
        rst = 1'b1; in_valid = 1'b0; in_text = '0; in_key = '0; flush = 1'b0;
        out_ready = 1'b0; aes_done = 1'b0; aes_cipher_text = '0;
        tick; tick;
        rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_last", 128'(out_last), 128'd0);
        chk("rst_start", 128'(aes_start), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);

        $display("[TB] full batch");
        load_vectors(0);
        for (int j = 0; j < N; j++) push(vt[j], vk[j]);
        chk("start_pulse", 128'(aes_start), 128'd1);
        chk("launch_in_ready", 128'(in_ready), 128'd0);
        chk("busy_launch", 128'(busy), 128'd1);
        check_lanes(N);
        tick;
        chk("start_one_cycle", 128'(aes_start), 128'd0);
        repeat (19) tick;
        chk("no_out_before_done", 128'(out_valid), 128'd0);
        set_cipher(1);
        aes_done = 1'b1;
        drain(N, 1'b0);
        aes_done = 1'b0;

        $display("[TB] partial flush with backpressure");
        load_vectors(16);
        push(vt[0], vk[0]);
        push(vt[1], vk[1]);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_start", 128'(aes_start), 128'd1);
        check_lanes(2);
        repeat (4) tick;
        set_cipher(2);
        aes_done = 1'b1;
        drain(2, 1'b1);
        aes_done = 1'b0;

        $display("[TB] full batch with backpressure");
        load_vectors(32);
        for (int j = 0; j < N; j++) push(vt[j], vk[j]);
        repeat (3) tick;
        set_cipher(3);
        aes_done = 1'b1;
        drain(N, 1'b1);
        aes_done = 1'b0;

        $display("[TB] stale done");
        set_cipher(9);
        aes_done = 1'b1;
        load_vectors(48);
        for (int j = 0; j < N; j++) push(vt[j], vk[j]);
        chk("stale_start", 128'(aes_start), 128'd1);
        repeat (5) tick;
        chk("stale_no_capture", 128'(out_valid), 128'd0);
        aes_done = 1'b0;
        repeat (3) tick;
        chk("stale_still_wait", 128'(out_valid), 128'd0);
        set_cipher(5);
        aes_done = 1'b1;
        drain(N, 1'b0);
        aes_done = 1'b0;

        $display("[TB] flush with empty batch");
        flush = 1'b1;
        starts = 0;
        repeat (3) begin
            tick;
            starts += int'(aes_start);
        end
        flush = 1'b0;
        chk("empty_flush_no_start", 128'(starts), 128'd0);
        chk("empty_flush_busy", 128'(busy), 128'd0);

        $display("[TB] flush with final handshake");
        load_vectors(64);
        for (int j = 0; j < N - 1; j++) push(vt[j], vk[j]);
        flush = 1'b1;
        push(vt[N-1], vk[N-1]);
        chk("flush4_start", 128'(aes_start), 128'd1);
        check_lanes(N);
        tick;
        flush = 1'b0;
        starts = 0;
        repeat (22) begin
            tick;
            starts += int'(aes_start);
        end
        chk("flush4_one_pulse", 128'(starts), 128'd0);
        set_cipher(6);
        aes_done = 1'b1;
        drain(N, 1'b0);
        aes_done = 1'b0;

        $display("[TB] reset during WAIT");
        load_vectors(80);
        for (int j = 0; j < N; j++) push(vt[j], vk[j]);
        repeat (3) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_slots", aes_plain_text[127:0], 128'h0);
        set_cipher(7);
        aes_done = 1'b1;
        repeat (5) tick;
        chk("mid_rst_no_out", 128'(out_valid), 128'd0);
        chk("mid_rst_in_ready2", 128'(in_ready), 128'd1);
        aes_done = 1'b0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
